// File: rtl/pm_port_arbiter_pkg.sv
// Shared types for the principal-memory port arbiter.
// FSM encodings, latched request bundle, default timeout data.
package pm_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } pm_state_t;

   localparam logic [31:0] PM_TIMEOUT_DATA = 32'hDEADBEEF;

   typedef struct packed {
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } pm_req_t;

   function automatic pm_req_t pm_pick(
      input logic    sel,
      input pm_req_t r0,
      input pm_req_t r1
   );
      return sel ? r1 : r0;
   endfunction

endpackage

// File: rtl/pm_port_arbiter_rr2.sv
// Two-way request arbiter: round-robin or fixed priority.
// Purely combinational; the caller owns last_grant.
module pm_port_arbiter_rr2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       fixed_prio,
   output logic       any,
   output logic       grant
);

   // pick a winner: lone requester wins, ties by mode
   always_comb begin
      any   = |req;
      grant = 1'b0;
      case (req)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = fixed_prio ? 1'b0 : ~last_grant;
         default: grant = 1'b0;
      endcase
   end

endmodule

// File: rtl/pm_port_arbiter.sv
// Shares the principal-memory port between two requesters.
// One transaction at a time, with a watchdog for stuck responses.
module pm_port_arbiter
   import pm_port_arbiter_pkg::*;
#(
   parameter int          PRIORITY_MODE  = 0,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] TIMEOUT_DATA   = PM_TIMEOUT_DATA
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m0_valid,
   input  logic        m0_instr,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic        m1_instr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        mem_valid_pm,
   output logic        mem_instr_pm,
   output logic [31:0] mem_addr_pm,
   output logic [31:0] mem_wdata_pm,
   output logic [3:0]  mem_wstrb_pm,
   input  logic        mem_ready_pm,
   input  logic [31:0] mem_rdata_pm,
   input  logic        timeout_clr,
   output logic        timeout_flag,
   output logic        grant_owner,
   output logic        busy
);

   localparam int CW =
      (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST =
      CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic WD_EN = (TIMEOUT_CYCLES != 0);

   pm_state_t     state;
   pm_state_t     state_n;
   logic [CW-1:0] cnt;
   logic          last_grant;
   logic          any;
   logic          gnt;
   logic          expire;
   logic          done_ok;
   logic          done_to;
   pm_req_t       r0;
   pm_req_t       r1;
   pm_req_t       rw;

   assign r0 = '{instr: m0_instr, addr: m0_addr,
                 wdata: m0_wdata, wstrb: m0_wstrb};
   assign r1 = '{instr: m1_instr, addr: m1_addr,
                 wdata: m1_wdata, wstrb: m1_wstrb};
   assign rw = pm_pick(gnt, r0, r1);

   pm_port_arbiter_rr2 u_arb (
      .req        ({m1_valid, m0_valid}),
      .last_grant (last_grant),
      .fixed_prio (PRIORITY_MODE != 0),
      .any        (any),
      .grant      (gnt)
   );

   // memory response beats the watchdog when both land together
   assign expire  = WD_EN & (cnt == CNT_LAST);
   assign done_ok = (state == ST_WAIT) & mem_ready_pm;
   assign done_to = (state == ST_WAIT) & ~mem_ready_pm & expire;

   // next-state decode
   always_comb begin
      state_n = state;
      unique case (state)
         ST_IDLE:  if (any) state_n = ST_ISSUE;
         ST_ISSUE: state_n = ST_WAIT;
         ST_WAIT:  if (done_ok | done_to) state_n = ST_RESP;
         ST_RESP:  state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
   end

   // state register and registered busy indication
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_n;
         busy  <= (state_n != ST_IDLE);
      end
   end

   // request latches, memory handshake, owner response, watchdog count
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_valid_pm <= 1'b0;
         mem_instr_pm <= 1'b0;
         mem_addr_pm  <= '0;
         mem_wdata_pm <= '0;
         mem_wstrb_pm <= '0;
         m0_ready     <= 1'b0;
         m1_ready     <= 1'b0;
         m0_rdata     <= '0;
         m1_rdata     <= '0;
         grant_owner  <= 1'b0;
         last_grant   <= 1'b1;
         cnt          <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (any) begin
                  {mem_instr_pm, mem_addr_pm,
                   mem_wdata_pm, mem_wstrb_pm} <= rw;
                  grant_owner <= gnt;
               end
            end
            ST_ISSUE: begin
               mem_valid_pm <= 1'b1;
               cnt          <= '0;
            end
            ST_WAIT: begin
               if (done_ok | done_to) begin
                  mem_valid_pm <= 1'b0;
                  if (grant_owner) begin
                     m1_ready <= 1'b1;
                     m1_rdata <= done_ok ? mem_rdata_pm
                                         : TIMEOUT_DATA;
                  end else begin
                     m0_ready <= 1'b1;
                     m0_rdata <= done_ok ? mem_rdata_pm
                                         : TIMEOUT_DATA;
                  end
               end else if (cnt != {CW{1'b1}}) begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_RESP: begin
               m0_ready   <= 1'b0;
               m1_ready   <= 1'b0;
               last_grant <= grant_owner;
            end
            default: ;
         endcase
      end
   end

   // sticky watchdog flag; a new timeout overrides a clear
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         timeout_flag <= 1'b0;
      else if (done_to)
         timeout_flag <= 1'b1;
      else if (timeout_clr)
         timeout_flag <= 1'b0;
   end

endmodule

// File: tb/tb_pm_port_arbiter.sv
// Bench for pm_port_arbiter: round-robin unit with an 8-cycle
// watchdog, plus a fixed-priority unit for starvation.
module tb_pm_port_arbiter;

   localparam logic [31:0] K   = 32'h12345778;
   localparam logic [31:0] TOD = 32'hDEADBEEF;

   logic        clk;
   logic        resetn;
   logic        m0_valid, m0_instr, m0_ready;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic [3:0]  m0_wstrb;
   logic        m1_valid, m1_instr, m1_ready;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m1_wstrb;
   logic        mem_valid_pm, mem_instr_pm, mem_ready_pm;
   logic [31:0] mem_addr_pm, mem_wdata_pm, mem_rdata_pm;
   logic [3:0]  mem_wstrb_pm;
   logic        timeout_clr, timeout_flag, grant_owner, busy;

   logic        p_m0_valid, p_m1_valid, p_m0_ready, p_m1_ready;
   logic [31:0] p_m0_rdata, p_m1_rdata;
   logic        p_mem_valid, p_mem_instr, p_mem_ready;
   logic [31:0] p_mem_addr, p_mem_wdata;
   logic [3:0]  p_mem_wstrb;
   logic        p_flag, p_owner, p_busy;

   logic mem_mute;
   int   mem_lat;
   int   mcnt;
   int   n_chk;
   int   n_fail;

   typedef struct {
      bit          port;
      logic [31:0] data;
   } exp_t;
   exp_t q[$];

   typedef struct {
      bit v0;
      bit v1;
      bit exp_port;
   } vec_t;
   vec_t tbl[8];

   pm_port_arbiter #(
      .PRIORITY_MODE  (0),
      .TIMEOUT_CYCLES (8)
   ) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .m0_valid     (m0_valid),
      .m0_instr     (m0_instr),
      .m0_addr      (m0_addr),
      .m0_wdata     (m0_wdata),
      .m0_wstrb     (m0_wstrb),
      .m0_ready     (m0_ready),
      .m0_rdata     (m0_rdata),
      .m1_valid     (m1_valid),
      .m1_instr     (m1_instr),
      .m1_addr      (m1_addr),
      .m1_wdata     (m1_wdata),
      .m1_wstrb     (m1_wstrb),
      .m1_ready     (m1_ready),
      .m1_rdata     (m1_rdata),
      .mem_valid_pm (mem_valid_pm),
      .mem_instr_pm (mem_instr_pm),
      .mem_addr_pm  (mem_addr_pm),
      .mem_wdata_pm (mem_wdata_pm),
      .mem_wstrb_pm (mem_wstrb_pm),
      .mem_ready_pm (mem_ready_pm),
      .mem_rdata_pm (mem_rdata_pm),
      .timeout_clr  (timeout_clr),
      .timeout_flag (timeout_flag),
      .grant_owner  (grant_owner),
      .busy         (busy)
   );

   pm_port_arbiter #(
      .PRIORITY_MODE (1)
   ) u_fp (
      .clk          (clk),
      .resetn       (resetn),
      .m0_valid     (p_m0_valid),
      .m0_instr     (1'b0),
      .m0_addr      (32'h10),
      .m0_wdata     (32'h0),
      .m0_wstrb     (4'h0),
      .m0_ready     (p_m0_ready),
      .m0_rdata     (p_m0_rdata),
      .m1_valid     (p_m1_valid),
      .m1_instr     (1'b0),
      .m1_addr      (32'h20),
      .m1_wdata     (32'h0),
      .m1_wstrb     (4'h0),
      .m1_ready     (p_m1_ready),
      .m1_rdata     (p_m1_rdata),
      .mem_valid_pm (p_mem_valid),
      .mem_instr_pm (p_mem_instr),
      .mem_addr_pm  (p_mem_addr),
      .mem_wdata_pm (p_mem_wdata),
      .mem_wstrb_pm (p_mem_wstrb),
      .mem_ready_pm (p_mem_ready),
      .mem_rdata_pm (32'h0BAD_F00D),
      .timeout_clr  (1'b0),
      .timeout_flag (p_flag),
      .grant_owner  (p_owner),
      .busy         (p_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // principal memory: answers mem_lat+1 edges after valid,
   // data derived from the latched address
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_ready_pm <= 1'b0;
         mem_rdata_pm <= '0;
         mcnt         <= 0;
      end else if (mem_valid_pm && !mem_ready_pm && !mem_mute) begin
         if (mcnt >= mem_lat) begin
            mem_ready_pm <= 1'b1;
            mem_rdata_pm <= mem_addr_pm ^ K;
            mcnt         <= 0;
         end else begin
            mcnt <= mcnt + 1;
         end
      end else begin
         mem_ready_pm <= 1'b0;
         mcnt         <= 0;
      end
   end

   // fast memory for the fixed-priority unit
   always @(posedge clk or negedge resetn) begin
      if (!resetn) p_mem_ready <= 1'b0;
      else         p_mem_ready <= p_mem_valid & ~p_mem_ready;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got hang, expected finish");
      $fatal(1, "bench time limit");
   end

   task automatic chk(input string name,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic req(input bit p, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] ws,
                      input bit ins, input logic [31:0] expd);
      if (p) begin
         m1_valid = 1'b1; m1_addr = a; m1_wdata = wd;
         m1_wstrb = ws; m1_instr = ins;
      end else begin
         m0_valid = 1'b1; m0_addr = a; m0_wdata = wd;
         m0_wstrb = ws; m0_instr = ins;
      end
      q.push_back('{port: p, data: expd});
   endtask

   task automatic drop();
      m0_valid = 1'b0;
      m1_valid = 1'b0;
   endtask

   // waits for a completion, pops the scoreboard and compares;
   // optionally checks the latched memory request every WAIT cycle
   task automatic wait_resp(input int budget, input bit cl,
                            input logic [31:0] la,
                            input logic [31:0] wd,
                            input logic [3:0] ws, input bit ins,
                            output int vcyc, output logic flag_at);
      exp_t e;
      bit   seen;
      seen    = 0;
      vcyc    = 0;
      flag_at = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (m0_ready || m1_ready) begin
            seen = 1;
         end else if (mem_valid_pm) begin
            vcyc++;
            if (cl) begin
               chk("lat_addr", mem_addr_pm, la);
               chk("lat_wdata", mem_wdata_pm, wd);
               chk("lat_wstrb", 32'(mem_wstrb_pm), 32'(ws));
               chk("lat_instr", 32'(mem_instr_pm), 32'(ins));
            end
         end
      end
      if (!seen) begin
         chk("resp_wait_expired", 0, 1);
         return;
      end
      flag_at = timeout_flag;
      if (q.size() == 0) begin
         chk("scoreboard_empty", 0, 1);
         return;
      end
      e = q.pop_front();
      chk("one_hot_ready", 32'(m0_ready & m1_ready), 0);
      chk("owner_ready", 32'(m1_ready), 32'(e.port));
      chk("rdata", e.port ? m1_rdata : m0_rdata, e.data);
      chk("grant_owner", 32'(grant_owner), 32'(e.port));
      @(negedge clk);
      chk("ready_pulse", 32'(m0_ready | m1_ready), 0);
   endtask

   int   vc;
   logic fl;
   int   c0, c1;
   bit   got;

   initial begin
      n_chk = 0; n_fail = 0;
      resetn = 1'b1;
      m0_valid = 0; m0_instr = 0; m0_addr = 0;
      m0_wdata = 0; m0_wstrb = 0;
      m1_valid = 0; m1_instr = 0; m1_addr = 0;
      m1_wdata = 0; m1_wstrb = 0;
      p_m0_valid = 0; p_m1_valid = 0;
      timeout_clr = 0; mem_mute = 0; mem_lat = 0;

      // arbitration table: tie outcome follows the last grant
      tbl[0] = '{v0: 1, v1: 0, exp_port: 0};
      tbl[1] = '{v0: 0, v1: 1, exp_port: 1};
      tbl[2] = '{v0: 1, v1: 1, exp_port: 0};
      tbl[3] = '{v0: 1, v1: 1, exp_port: 1};
      tbl[4] = '{v0: 1, v1: 1, exp_port: 0};
      tbl[5] = '{v0: 0, v1: 1, exp_port: 1};
      tbl[6] = '{v0: 0, v1: 1, exp_port: 1};
      tbl[7] = '{v0: 1, v1: 1, exp_port: 0};

      #2 resetn = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_mem_valid", 32'(mem_valid_pm), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'({m0_ready, m1_ready}), 0);
      chk("rst_flag", 32'(timeout_flag), 0);
      chk("rst_owner", 32'(grant_owner), 0);
      chk("rst_addr", mem_addr_pm, 0);
      resetn = 1'b1;
      @(negedge clk);

      // single read, memory answers a few cycles later
      mem_lat = 2;
      req(0, 32'h100, 0, 4'h0, 1, 32'h12345678);
      wait_resp(40, 1, 32'h100, 0, 4'h0, 1, vc, fl);
      drop();
      chk("t1_flag", 32'(timeout_flag), 0);

      // table-driven arbitration
      mem_lat = 0;
      for (int i = 0; i < 8; i++) begin
         logic [31:0] a0, a1;
         a0 = 32'h1000 + 32'(i * 4);
         a1 = 32'h2000 + 32'(i * 4);
         if (tbl[i].v0) begin
            m0_valid = 1; m0_addr = a0; m0_wstrb = 0;
         end
         if (tbl[i].v1) begin
            m1_valid = 1; m1_addr = a1; m1_wstrb = 0;
         end
         q.push_back('{port: tbl[i].exp_port,
                       data: (tbl[i].exp_port ? a1 : a0) ^ K});
         wait_resp(40, 0, 0, 0, 0, 0, vc, fl);
         drop();
      end

      // both held high: last grant was port 0, so 1,0,1,0
      m0_valid = 1; m0_addr = 32'h3000;
      m1_valid = 1; m1_addr = 32'h4000;
      for (int i = 0; i < 4; i++)
         q.push_back('{port: (i % 2 == 0),
                       data: ((i % 2 == 0) ? 32'h4000 : 32'h3000) ^ K});
      for (int i = 0; i < 4; i++)
         wait_resp(40, 0, 0, 0, 0, 0, vc, fl);
      drop();

      // write; requester inputs change once the request is out
      mem_lat = 4;
      req(1, 32'h200, 32'hA5A5, 4'b0011, 0, 32'h200 ^ K);
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (mem_valid_pm) got = 1;
      end
      chk("t3_issue_seen", 32'(got), 1);
      m1_addr = 32'h300; m1_wdata = 0; m1_wstrb = 0; m1_valid = 0;
      wait_resp(40, 1, 32'h200, 32'hA5A5, 4'b0011, 0, vc, fl);

      // memory never answers: watchdog after 8 WAIT cycles
      mem_mute = 1;
      req(0, 32'h40, 0, 0, 0, TOD);
      wait_resp(40, 0, 0, 0, 0, 0, vc, fl);
      drop();
      chk("t4_wait_cycles", 32'(vc), 8);
      chk("t4_flag_set", 32'(fl), 1);
      chk("t4_flag_sticky", 32'(timeout_flag), 1);
      timeout_clr = 1;
      @(negedge clk);
      timeout_clr = 0;
      chk("t4_flag_clr", 32'(timeout_flag), 0);

      // clear held across a new timeout: set wins
      timeout_clr = 1;
      req(1, 32'h44, 0, 0, 0, TOD);
      wait_resp(40, 0, 0, 0, 0, 0, vc, fl);
      drop();
      chk("t4_set_wins", 32'(fl), 1);
      chk("t4_clr_after", 32'(timeout_flag), 0);
      timeout_clr = 0;

      // response lands on the expiry cycle: data wins, no flag
      mem_mute = 0;
      mem_lat  = 6;
      req(1, 32'h80, 0, 0, 0, 32'h80 ^ K);
      wait_resp(40, 0, 0, 0, 0, 0, vc, fl);
      drop();
      chk("t5_wait_cycles", 32'(vc), 8);
      chk("t5_no_flag", 32'(fl), 0);

      // one cycle later it is a timeout; late response dropped
      mem_lat = 7;
      req(0, 32'h84, 0, 0, 0, TOD);
      wait_resp(40, 0, 0, 0, 0, 0, vc, fl);
      drop();
      chk("t5_late_flag", 32'(fl), 1);
      c0 = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (m0_ready || m1_ready || busy) c0++;
      end
      chk("t5_late_ignored", 32'(c0), 0);
      timeout_clr = 1;
      @(negedge clk);
      timeout_clr = 0;

      // reset mid-WAIT abandons the request
      mem_mute = 1;
      req(1, 32'h300, 32'h11, 4'hF, 1, 0);
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (mem_valid_pm) got = 1;
      end
      chk("t6_in_wait", 32'(got), 1);
      @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("t6_mem_valid", 32'(mem_valid_pm), 0);
      chk("t6_addr", mem_addr_pm, 0);
      chk("t6_busy", 32'(busy), 0);
      chk("t6_owner", 32'(grant_owner), 0);
      q.delete();
      drop();
      @(negedge clk);
      resetn = 1'b1;
      mem_mute = 0;
      mem_lat  = 1;
      req(0, 32'h500, 0, 0, 0, 32'h500 ^ K);
      req(1, 32'h600, 0, 0, 0, 32'h600 ^ K);
      wait_resp(40, 0, 0, 0, 0, 0, vc, fl);
      wait_resp(40, 0, 0, 0, 0, 0, vc, fl);
      drop();

      // fixed priority: persistent port 0 starves port 1
      p_m0_valid = 1;
      p_m1_valid = 1;
      c0 = 0; c1 = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (p_m0_ready) c0++;
         if (p_m1_ready) c1++;
      end
      p_m0_valid = 0;
      p_m1_valid = 0;
      chk("fp_m1_starved", 32'(c1), 0);
      chk("fp_m0_served", 32'(c0 >= 5), 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
